rm802_bus_arbiter: RTL

- Sequencer and arbiter for the 8-bit dual-4-bit 2:1 bus multiplexer.
- Shares the mux between two requesters: A drives the mux a-side (select=0), B drives the b-side (select=1).
- Generates registered mux_select and mux_enable_n, and returns grants to the requesters.
- Arbitration is round-robin, with a bounded hold time and a one-cycle dead (disabled) cycle whenever ownership switches.

---
 rtl/rm802_bus_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rm802_bus_arbiter.sv
// ----------------------------------------------------------------------------
// rm802_bus_arbiter
//   Round-robin sequencer/arbiter sharing an 8-bit dual-4-bit 2:1 bus mux
//   between two requesters. A drives the mux a-side (select = 0) and B drives
//   the b-side (select = 1). Ownership is held for at most HOLD_MAX cycles while
//   the other side waits. Every change of owner passes through one disabled
//   TURN cycle, so select never moves while the mux is enabled.
//
//   Optional feature macro: RM802_ARB_LOCK_EN
//     Adds lock_a / lock_b. A locked owner is never preempted, and its hold
//     counter is frozen until the lock is dropped.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req_a/req_b  in   level requests, held until done
//   lock_a/b     in   (RM802_ARB_LOCK_EN only) suppress timeout while owning
//   gnt_a/gnt_b  out  ownership grants (registered)
//   mux_select   out  mux select, 0 = a, 1 = b (registered)
//   mux_enable_n out  mux enable_n, 1 forces y = 0x00 (registered)
//   busy         out  high in GRANT_A, GRANT_B or TURN
//   preempt      out  one-cycle pulse when a grant is revoked by timeout
// ----------------------------------------------------------------------------
module rm802_bus_arbiter #(
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
`ifdef RM802_ARB_LOCK_EN
    input  logic lock_a,
    input  logic lock_b,
`endif
    output logic gnt_a,
    output logic gnt_b,
    output logic mux_select,
    output logic mux_enable_n,
    output logic busy,
    output logic preempt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2,
        TURN    = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);

    state_e           state_q, state_d;
    logic             gnt_a_q, gnt_a_d;
    logic             gnt_b_q, gnt_b_d;
    logic             sel_q, sel_d;
    logic             en_n_q, en_n_d;
    logic             busy_q, busy_d;
    logic             pre_q, pre_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             last_q, last_d;    // 1 = B owned last

    logic own_b, own_req, oth_req, locked, timeout;
    logic go_grant, go_turn, go_idle, go_b;

    assign own_b   = (state_q == GRANT_B);
    assign own_req = own_b ? req_b : req_a;
    assign oth_req = own_b ? req_a : req_b;
    // Compared with >= so that an owner whose counter has already saturated
    // (held alone beyond HOLD_MAX) is still preempted when the other side arrives.
    assign timeout = (hold_q >= HOLD_LAST);

`ifdef RM802_ARB_LOCK_EN
    assign locked = ((state_q == GRANT_A) && lock_a) || ((state_q == GRANT_B) && lock_b);
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_a_d  = gnt_a_q;
        gnt_b_d  = gnt_b_q;
        sel_d    = sel_q;
        en_n_d   = en_n_q;
        busy_d   = busy_q;
        pre_d    = 1'b0;
        hold_d   = hold_q;
        last_d   = last_q;
        go_grant = 1'b0;
        go_turn  = 1'b0;
        go_idle  = 1'b0;
        go_b     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    go_grant = 1'b1;
                    go_b     = ~last_q;
                end else if (req_a || req_b) begin
                    go_grant = 1'b1;
                    go_b     = req_b;
                end
            end
            GRANT_A, GRANT_B: begin
                if (!own_req) begin
                    // A release wins over a coincident timeout: no preempt pulse.
                    if (oth_req) begin
                        go_turn = 1'b1;
                        go_b    = ~own_b;
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (oth_req && timeout && !locked) begin
                    go_turn = 1'b1;
                    go_b    = ~own_b;
                    pre_d   = 1'b1;
                end else if (!locked && (hold_q != HOLD_SAT)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TURN: begin
                // sel_q already names the incoming side; fall back to the
                // outgoing side if the incoming one has gone away.
                if (sel_q ? req_b : req_a) begin
                    go_grant = 1'b1;
                    go_b     = sel_q;
                end else if (sel_q ? req_a : req_b) begin
                    go_grant = 1'b1;
                    go_b     = ~sel_q;
                end else begin
                    go_idle = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_grant) begin
            state_d = go_b ? GRANT_B : GRANT_A;
            gnt_a_d = ~go_b;
            gnt_b_d = go_b;
            sel_d   = go_b;
            en_n_d  = 1'b0;
            busy_d  = 1'b1;
            last_d  = go_b;
            hold_d  = '0;
        end else if (go_turn) begin
            state_d = TURN;
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
            sel_d   = go_b;
            en_n_d  = 1'b1;
            busy_d  = 1'b1;
        end else if (go_idle) begin
            state_d = IDLE;
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
            en_n_d  = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            sel_q   <= 1'b0;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            pre_q   <= 1'b0;
            hold_q  <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            sel_q   <= sel_d;
            en_n_q  <= en_n_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign gnt_a        = gnt_a_q;
    assign gnt_b        = gnt_b_q;
    assign mux_select   = sel_q;
    assign mux_enable_n = en_n_q;
    assign busy         = busy_q;
    assign preempt      = pre_q;

endmodule
